// File: rtl/test_result_arbiter_if.sv
// Requester-side handshake bus for test_result_arbiter: per-requester valid/ready
// plus the packed (value, expected) pairs, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
interface test_result_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_value;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_expected;

    modport master (output req_valid, req_value, req_expected, input req_ready);
    modport slave  (input req_valid, req_value, req_expected, output req_ready);
endinterface

// File: rtl/test_result_arbiter.sv
// Round-robin shared compare-and-count unit with end-of-test drain and sticky verdict.
// Optional idle watchdog enabled by defining TEST_RESULT_TIMEOUT_EN.
module test_result_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    test_result_arbiter_if.slave       req,
    input  logic                       test_done,
    output logic                       check_valid,
    output logic [$clog2(NUM_REQ)-1:0] check_id,
    output logic                       check_mismatch,
    output logic [31:0]                check_count,
    output logic [31:0]                fail_count,
    output logic                       busy,
    output logic                       test_passed,
    output logic                       test_failed,
    output logic                       timeout
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t                state;
    logic [ID_W-1:0]       ptr;
    logic                  running;
    logic                  grant_any;
    logic [ID_W-1:0]       grant_idx;
    logic [ID_W:0]         sum;
    logic                  xfer;
    logic                  mism;
    logic                  timeout_hit;
    logic [DATA_WIDTH-1:0] sel_value;
    logic [DATA_WIDTH-1:0] sel_expected;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    // Scanning offsets from the far end lets the nearest valid requester overwrite the rest.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        sum       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (ID_W + 1)'(k);
            if (sum >= (ID_W + 1)'(NUM_REQ))
                sum = sum - (ID_W + 1)'(NUM_REQ);
            if (req.req_valid[sum[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_value    = '0;
        sel_expected = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_value    = req.req_value[i*DATA_WIDTH +: DATA_WIDTH];
                sel_expected = req.req_expected[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign xfer          = grant_any && (state != DONE);
    assign mism          = (sel_value != sel_expected);
    assign req.req_ready = xfer ? (NUM_REQ'(1) << grant_idx) : '0;
    assign busy          = running && (state != DONE);

`ifdef TEST_RESULT_TIMEOUT_EN
    logic [31:0] idle_cnt;

    // A transfer on the limit edge clears the count, so it always beats the watchdog.
    assign timeout_hit = (state != DONE) && !xfer &&
                         (idle_cnt + 32'd1 == 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else if (state != DONE) begin
            idle_cnt <= xfer ? '0 : idle_cnt + 32'd1;
            if (timeout_hit)
                timeout <= 1'b1;
        end
    end
`else
    localparam int timeout_cycles_unused = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= RUN;
            ptr            <= '0;
            running        <= 1'b0;
            check_valid    <= 1'b0;
            check_id       <= '0;
            check_mismatch <= 1'b0;
            check_count    <= '0;
            fail_count     <= '0;
            test_passed    <= 1'b0;
            test_failed    <= 1'b0;
        end else begin
            running     <= 1'b1;
            check_valid <= xfer;
            if (xfer) begin
                ptr            <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                check_id       <= grant_idx;
                check_mismatch <= mism;
                if (check_count != '1)
                    check_count <= check_count + 32'd1;
                if (mism && (fail_count != '1))
                    fail_count <= fail_count + 32'd1;
            end

            unique case (state)
                RUN: begin
                    if (timeout_hit) begin
                        state       <= DONE;
                        test_failed <= 1'b1;
                    end else if (test_done) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (timeout_hit) begin
                        state       <= DONE;
                        test_failed <= 1'b1;
                    end else if (!(|req.req_valid)) begin
                        // No transfer can happen on this edge, so fail_count is already final.
                        state <= DONE;
                        if (fail_count != '0)
                            test_failed <= 1'b1;
                        else
                            test_passed <= 1'b1;
                    end
                end
                DONE:    state <= DONE;
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_test_result_arbiter.sv
// Self-checking bench for test_result_arbiter: hand sequences, a constant vector table,
// and randomized traffic against a behavioural model.
module tb_test_result_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        test_done;
    logic        check_valid;
    logic [1:0]  check_id;
    logic        check_mismatch;
    logic [31:0] check_count;
    logic [31:0] fail_count;
    logic        busy;
    logic        test_passed;
    logic        test_failed;
    logic        timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    test_result_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bus ();

    test_result_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (bus.slave),
        .test_done      (test_done),
        .check_valid    (check_valid),
        .check_id       (check_id),
        .check_mismatch (check_mismatch),
        .check_count    (check_count),
        .fail_count     (fail_count),
        .busy           (busy),
        .test_passed    (test_passed),
        .test_failed    (test_failed),
        .timeout        (timeout)
    );

    typedef struct {
        logic [3:0] valid;
        logic [3:0] bad;
        logic       done;
        logic [3:0] exp_ready;
        logic       exp_cv;
        int         exp_id;
        logic       exp_mism;
        int         exp_cnt;
        int         exp_fail;
        logic       exp_pass;
        logic       exp_failv;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[16];

    // Behavioural model state for the random phase.
    int          m_ptr, m_count, m_fail, m_id;
    logic        m_mism, m_draining, m_done, m_passed, m_failed;
    logic [31:0] rv[N];
    logic [31:0] re[N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic cv, input int id, input logic mm,
                              input int cnt, input int fl, input logic p, input logic f,
                              input logic b);
        check({tag, ".check_valid"},    check_valid,    cv);
        check({tag, ".check_id"},       check_id,       id);
        check({tag, ".check_mismatch"}, check_mismatch, mm);
        check({tag, ".check_count"},    check_count,    cnt);
        check({tag, ".fail_count"},     fail_count,     fl);
        check({tag, ".test_passed"},    test_passed,    p);
        check({tag, ".test_failed"},    test_failed,    f);
        check({tag, ".busy"},           busy,           b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        test_done     = 1'b0;
        reset_n       = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    // Requester i presents a fixed value; a set bad bit flips one bit of its expected word.
    task automatic load(input logic [3:0] valid, input logic [3:0] bad);
        for (int i = 0; i < N; i++) begin
            bus.req_value[i*W +: W]    = 32'hC0DE_0000 + 32'(i);
            bus.req_expected[i*W +: W] = bad[i] ? ((32'hC0DE_0000 + 32'(i)) ^ 32'h80)
                                                : (32'hC0DE_0000 + 32'(i));
        end
        bus.req_valid = valid;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_count = 0; m_fail = 0; m_id = 0;
        m_mism = 0; m_draining = 0; m_done = 0; m_passed = 0; m_failed = 0;
    endtask

    task automatic model_cycle(input logic [3:0] v, input logic [3:0] bad, input logic done);
        int         g;
        logic [3:0] exp_rdy;
        logic       was_drain;
        for (int i = 0; i < N; i++) begin
            rv[i] = $urandom;
            re[i] = bad[i] ? (rv[i] ^ (32'h1 << $urandom_range(0, 31))) : rv[i];
            bus.req_value[i*W +: W]    = rv[i];
            bus.req_expected[i*W +: W] = re[i];
        end
        bus.req_valid = v;
        test_done     = done;
        g = -1;
        if (!m_done)
            for (int k = 0; k < N; k++)
                if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        #1 check("rand.ready", bus.req_ready, exp_rdy);
        tick();
        was_drain = m_draining;
        if (g >= 0) begin
            m_count++;
            m_id   = g;
            m_mism = (rv[g] != re[g]);
            if (m_mism) m_fail++;
            m_ptr = (g + 1) % N;
        end
        if (!m_done) begin
            if (was_drain && v == 4'b0000) begin
                m_done   = 1;
                m_passed = (m_fail == 0);
                m_failed = (m_fail != 0);
            end else if (!was_drain && done) begin
                m_draining = 1;
            end
        end
        expect_out("rand", g >= 0, m_id, m_mism, m_count, m_fail, m_passed, m_failed, !m_done);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        vecs[0]  = '{4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b1, 0, 1'b0,  1, 0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{4'b1111, 4'b0000, 1'b0, 4'b0010, 1'b1, 1, 1'b0,  2, 0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{4'b1111, 4'b0000, 1'b0, 4'b0100, 1'b1, 2, 1'b0,  3, 0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{4'b1111, 4'b0000, 1'b0, 4'b1000, 1'b1, 3, 1'b0,  4, 0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b1, 0, 1'b0,  5, 0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{4'b1111, 4'b0000, 1'b0, 4'b0010, 1'b1, 1, 1'b0,  6, 0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{4'b1111, 4'b0000, 1'b0, 4'b0100, 1'b1, 2, 1'b0,  7, 0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{4'b1111, 4'b0000, 1'b0, 4'b1000, 1'b1, 3, 1'b0,  8, 0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{4'b0101, 4'b0001, 1'b0, 4'b0001, 1'b1, 0, 1'b1,  9, 1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{4'b0101, 4'b0001, 1'b0, 4'b0100, 1'b1, 2, 1'b0, 10, 1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2, 1'b0, 10, 1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{4'b1010, 4'b1000, 1'b1, 4'b1000, 1'b1, 3, 1'b1, 11, 2, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{4'b1010, 4'b1000, 1'b0, 4'b0010, 1'b1, 1, 1'b0, 12, 2, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1, 3, 1'b1, 13, 3, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 3, 1'b1, 13, 3, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 3, 1'b1, 13, 3, 1'b0, 1'b1, 1'b0};

        // Reset state
        reset_n          = 1'b0;
        test_done        = 1'b0;
        bus.req_valid    = '0;
        bus.req_value    = '0;
        bus.req_expected = '0;
        #2;
        expect_out("reset", 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("reset.ready", bus.req_ready, 4'b0000);
        check("reset.timeout", timeout, 1'b0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        check("release.busy", busy, 1'b0);
        tick();
        check("first_edge.busy", busy, 1'b1);

        // Single match on requester 2, then verdict one edge after DRAIN
        bus.req_value[2*W +: W]    = 32'h1234;
        bus.req_expected[2*W +: W] = 32'h1234;
        bus.req_valid              = 4'b0100;
        #1 check("match.ready", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = 4'b0000;
        expect_out("match", 1'b1, 2, 1'b0, 1, 0, 1'b0, 1'b0, 1'b1);
        test_done = 1'b1;
        tick();
        test_done = 1'b0;
        check("match.drain_passed", test_passed, 1'b0);
        check("match.drain_busy", busy, 1'b1);
        tick();
        expect_out("match.verdict", 1'b0, 2, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0);

        // Mismatch on requester 0
        do_reset();
        bus.req_value[0*W +: W]    = 32'h5;
        bus.req_expected[0*W +: W] = 32'h6;
        bus.req_valid              = 4'b0001;
        tick();
        bus.req_valid = 4'b0000;
        expect_out("mism", 1'b1, 0, 1'b1, 1, 1, 1'b0, 1'b0, 1'b1);
        test_done = 1'b1;
        tick();
        test_done = 1'b0;
        tick();
        expect_out("mism.verdict", 1'b0, 0, 1'b1, 1, 1, 1'b0, 1'b1, 1'b0);

        // Reset mid-test clears everything asynchronously
        do_reset();
        load(4'b0111, 4'b0010);
        repeat (3) tick();
        check("midreset.pre_count", check_count, 3);
        check("midreset.pre_fail", fail_count, 1);
        #2 reset_n = 1'b0;
        #1;
        check("midreset.count", check_count, 0);
        check("midreset.fail", fail_count, 0);
        check("midreset.check_valid", check_valid, 1'b0);
        check("midreset.check_id", check_id, 0);
        bus.req_valid = 4'b0000;
        #2 reset_n = 1'b1;
        tick();
        test_done = 1'b1;
        tick();
        test_done = 1'b0;
        tick();
        expect_out("midreset.verdict", 1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);

        // Vector table: round-robin, hold, drain and DONE lockout
        do_reset();
        for (int t = 0; t < 16; t++) begin
            load(vecs[t].valid, vecs[t].bad);
            test_done = vecs[t].done;
            #1 check($sformatf("vec%0d.ready", t), bus.req_ready, vecs[t].exp_ready);
            tick();
            test_done = 1'b0;
            expect_out($sformatf("vec%0d", t), vecs[t].exp_cv, vecs[t].exp_id, vecs[t].exp_mism,
                       vecs[t].exp_cnt, vecs[t].exp_fail, vecs[t].exp_pass, vecs[t].exp_failv,
                       vecs[t].exp_busy);
        end

        // Randomized traffic against the model, ending with an end-of-test request
        do_reset();
        model_reset();
        for (int c = 0; c < 300; c++) begin
            logic [3:0] v, b;
            v = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) b[i] = ($urandom_range(0, 3) == 0);
            model_cycle(v, b, (c > 250) && ($urandom_range(0, 7) == 0));
        end
        for (int c = 0; c < 4; c++) model_cycle(4'b0000, 4'b0000, 1'b1);
        model_cycle(4'b1111, 4'b0000, 1'b0);

`ifdef TEST_RESULT_TIMEOUT_EN
        // Watchdog fires on the TO-th idle edge
        do_reset();
        for (int e = 1; e <= TO; e++) begin
            tick();
            check($sformatf("wd%0d.timeout", e), timeout, e == TO);
        end
        check("wd.failed", test_failed, 1'b1);
        check("wd.passed", test_passed, 1'b0);
        check("wd.busy", busy, 1'b0);

        // A transfer on edge 9 restarts the idle count
        do_reset();
        for (int e = 1; e <= 9 + TO; e++) begin
            if (e == 9) load(4'b0001, 4'b0000);
            else bus.req_valid = 4'b0000;
            tick();
            check($sformatf("wdr%0d.timeout", e), timeout, e == 9 + TO);
        end
        check("wdr.failed", test_failed, 1'b1);
        check("wdr.count", check_count, 1);
`else
        // Without the watchdog the block idles in RUN indefinitely
        do_reset();
        repeat (3 * TO) tick();
        check("idle.timeout", timeout, 1'b0);
        check("idle.busy", busy, 1'b1);
        check("idle.failed", test_failed, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
